// File: rtl/lab3_mem_refill_arbiter.sv
// Purpose : merges the cacheline memreq streams of two blocking caches (port 0 = icache,
//           port 1 = dcache) onto one memory port and routes responses back in order.
// Latency : zero cycles on both paths. Requests and responses pass straight through.
// Backpressure: a request is accepted only while the in-order ID FIFO has room.
//           A response is accepted only when the owning cache is ready.
//
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   req0_* / req1_*        val/rdy/msg request inputs from icache / dcache
//   memreq_*               val/rdy/msg granted request toward memory
//   memresp_*              val/rdy/msg response from memory
//   resp0_* / resp1_*      val/rdy/msg responses back to icache / dcache
//   num_grants0/1, num_stall  32-bit statistics counters, present only when
//                          LAB3_MEM_ARB_STATS_EN is defined
//
// Messages are opaque bit vectors and are never modified.

module lab3_mem_refill_arbiter #(
   parameter int p_req_nbits       = 175,
   parameter int p_resp_nbits      = 145,
   parameter int p_num_outstanding = 2
)(
   input  logic                    clk,
   input  logic                    reset,

   input  logic                    req0_val,
   output logic                    req0_rdy,
   input  logic [p_req_nbits-1:0]  req0_msg,

   input  logic                    req1_val,
   output logic                    req1_rdy,
   input  logic [p_req_nbits-1:0]  req1_msg,

   output logic                    memreq_val,
   input  logic                    memreq_rdy,
   output logic [p_req_nbits-1:0]  memreq_msg,

   input  logic                    memresp_val,
   output logic                    memresp_rdy,
   input  logic [p_resp_nbits-1:0] memresp_msg,

   output logic                    resp0_val,
   input  logic                    resp0_rdy,
   output logic [p_resp_nbits-1:0] resp0_msg,

   output logic                    resp1_val,
   input  logic                    resp1_rdy,
   output logic [p_resp_nbits-1:0] resp1_msg
`ifdef LAB3_MEM_ARB_STATS_EN
   ,
   output logic [31:0]             num_grants0,
   output logic [31:0]             num_grants1,
   output logic [31:0]             num_stall
`endif
);

   localparam int PTR_W = (p_num_outstanding > 1) ? $clog2(p_num_outstanding) : 1;
   localparam int CNT_W = $clog2(p_num_outstanding + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(p_num_outstanding - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(p_num_outstanding);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic                         prio_reg;   // port favoured on a tie
   logic [p_num_outstanding-1:0] id_fifo;    // one bit per outstanding request: issuing port
   logic [PTR_W-1:0]             enq_ptr;
   logic [PTR_W-1:0]             deq_ptr;
   logic [CNT_W-1:0]             count;

   logic fifo_full;
   logic fifo_empty;
   logic any_val;
   logic grant;
   logic head;
   logic req_fire;
   logic resp_fire;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   assign fifo_full  = (count == CNT_MAX);
   assign fifo_empty = (count == '0);
   assign head       = id_fifo[deq_ptr];

   // ---------------------------------------------------------------------
   // Request path
   // ---------------------------------------------------------------------
   // The tie-break only matters when both ports are valid. With neither valid, grant
   // defaults to 0, so req0_rdy still reflects downstream readiness. It depends on
   // the request valids only through grant selection.
   always_comb begin
      any_val = req0_val | req1_val;
      grant   = 1'b0;
      if (req0_val && req1_val) grant = prio_reg;
      else if (req1_val)        grant = 1'b1;
   end

   assign memreq_val = any_val & ~fifo_full;
   assign memreq_msg = !any_val ? '0 : (grant ? req1_msg : req0_msg);
   assign req0_rdy   = memreq_rdy & ~fifo_full & (grant == 1'b0);
   assign req1_rdy   = memreq_rdy & ~fifo_full & (grant == 1'b1);
   assign req_fire   = memreq_val & memreq_rdy;

   // ---------------------------------------------------------------------
   // Response path: memory returns in request order, so the FIFO head names the owner
   // ---------------------------------------------------------------------
   assign resp0_val   = memresp_val & ~fifo_empty & (head == 1'b0);
   assign resp1_val   = memresp_val & ~fifo_empty & (head == 1'b1);
   assign resp0_msg   = memresp_msg;
   assign resp1_msg   = memresp_msg;
   assign memresp_rdy = ~fifo_empty & (head ? resp1_rdy : resp0_rdy);
   assign resp_fire   = memresp_val & memresp_rdy;

   // ---------------------------------------------------------------------
   // Sequential state. A full FIFO blocks enqueue even in a cycle that dequeues,
   // so there is no combinational path from memresp to the request ports.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         prio_reg <= 1'b0;
         id_fifo  <= '0;
         enq_ptr  <= '0;
         deq_ptr  <= '0;
         count    <= '0;
      end else begin
         if (req_fire) begin
            id_fifo[enq_ptr] <= grant;
            enq_ptr          <= ptr_next(enq_ptr);
            prio_reg         <= ~grant;
         end
         if (resp_fire) begin
            deq_ptr <= ptr_next(deq_ptr);
         end
         case ({req_fire, resp_fire})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef LAB3_MEM_ARB_STATS_EN
   // Counters wrap naturally modulo 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         num_grants0 <= '0;
         num_grants1 <= '0;
         num_stall   <= '0;
      end else begin
         if (req_fire && !grant) num_grants0 <= num_grants0 + 32'd1;
         if (req_fire &&  grant) num_grants1 <= num_grants1 + 32'd1;
         if (any_val && !req_fire) num_stall <= num_stall + 32'd1;
      end
   end
`endif

   // A response with nothing outstanding cannot be routed and indicates a broken memory model.
   a_no_stray_resp: assert property (@(posedge clk) disable iff (reset)
                                     !(memresp_val && fifo_empty));

endmodule

// File: tb/tb_lab3_mem_refill_arbiter.sv
// Purpose : directed self-checking bench for lab3_mem_refill_arbiter.
// Ports   : none. The bench drives every DUT port and generates clk.
module tb_lab3_mem_refill_arbiter;

   logic         clk = 1'b0;
   logic         reset;
   logic         req0_val, req0_rdy;
   logic [174:0] req0_msg;
   logic         req1_val, req1_rdy;
   logic [174:0] req1_msg;
   logic         memreq_val, memreq_rdy;
   logic [174:0] memreq_msg;
   logic         memresp_val, memresp_rdy;
   logic [144:0] memresp_msg;
   logic         resp0_val, resp0_rdy;
   logic [144:0] resp0_msg;
   logic         resp1_val, resp1_rdy;
   logic [144:0] resp1_msg;
`ifdef LAB3_MEM_ARB_STATS_EN
   logic [31:0]  num_grants0, num_grants1, num_stall;
`endif

   always #5 clk = ~clk;

   lab3_mem_refill_arbiter dut (
      .clk(clk), .reset(reset),
      .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
      .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
      .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
      .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
      .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
      .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg)
`ifdef LAB3_MEM_ARB_STATS_EN
      ,
      .num_grants0(num_grants0), .num_grants1(num_grants1), .num_stall(num_stall)
`endif
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [174:0] mk_req(input logic [2:0] t, input logic [7:0] op,
                                           input logic [31:0] addr, input logic [127:0] data);
      return {t, op, addr, 4'd0, data};
   endfunction

   function automatic logic [144:0] mk_resp(input logic [2:0] t, input logic [7:0] op,
                                            input logic [127:0] data);
      return {t, op, 2'd0, 4'd0, data};
   endfunction

   task automatic idle_inputs();
      req0_val = 1'b0; req0_msg = '0;
      req1_val = 1'b0; req1_msg = '0;
      memresp_val = 1'b0; memresp_msg = '0;
      memreq_rdy = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
   endtask

`ifdef LAB3_MEM_ARB_STATS_EN
   // One request from port p, then its response one cycle later.
   task automatic do_txn(input logic p);
      @(negedge clk);
      memreq_rdy = 1'b1;
      if (p) req1_val = 1'b1; else req0_val = 1'b1;
      @(negedge clk);
      req0_val = 1'b0; req1_val = 1'b0;
      memresp_val = 1'b1; memresp_msg = mk_resp(3'd0, 8'h77, 128'h1);
      @(negedge clk);
      memresp_val = 1'b0;
   endtask
`endif

   logic [174:0] r0, r1, rc;
   logic [144:0] rs;
   logic         exp_g, exp_h;

   initial begin
      // ---------------- reset state ----------------
      reset = 1'b1;
      idle_inputs();
      memreq_rdy = 1'b0; resp0_rdy = 1'b0; resp1_rdy = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check("rst_memreq_val",  memreq_val,  0);
      check("rst_memresp_rdy", memresp_rdy, 0);
      check("rst_resp0_val",   resp0_val,   0);
      check("rst_resp1_val",   resp1_val,   0);
      check("rst_req0_rdy",    req0_rdy,    0);
      check("rst_req1_rdy",    req1_rdy,    0);
      reset = 1'b0;

      // ---------------- single port-0 read ----------------
      @(negedge clk);
      r0 = mk_req(3'd0, 8'h01, 32'h0000_1000, 128'h0);
      req0_val = 1'b1; req0_msg = r0; memreq_rdy = 1'b1;
      #1;
      check("t1_memreq_val", memreq_val, 1);
      check("t1_memreq_msg", memreq_msg, r0);
      check("t1_req0_rdy",   req0_rdy,   1);
      check("t1_req1_rdy",   req1_rdy,   0);
      @(negedge clk);
      req0_val = 1'b0; req0_msg = '0;
      rs = mk_resp(3'd0, 8'h05, 128'hCAFE_F00D);
      memresp_val = 1'b1; memresp_msg = rs; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
      #1;
      check("t1_idle_memreq_msg", memreq_msg, 0);
      check("t1_resp0_val",   resp0_val,   1);
      check("t1_resp1_val",   resp1_val,   0);
      check("t1_resp0_msg",   resp0_msg,   rs);
      check("t1_memresp_rdy", memresp_rdy, 1);
      @(negedge clk);
      memresp_val = 1'b0;
      #1;
      check("t1_fifo_empty", dut.count, 0);
      check("t1_resp0_done", resp0_val, 0);

      // ---------------- alternation after reset ----------------
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         r0 = mk_req(3'd0, 8'h10 + 8'(i), 32'h2000 + 32'(i * 16), 128'(i));
         r1 = mk_req(3'd0, 8'h20 + 8'(i), 32'h3000 + 32'(i * 16), 128'(i + 100));
         req0_val = (i < 4); req0_msg = r0;
         req1_val = (i < 4); req1_msg = r1;
         memresp_val = (i >= 1);
         memresp_msg = mk_resp(3'd0, 8'h30 + 8'(i), 128'(i));
         #1;
         if (i < 4) begin
            exp_g = (i % 2 == 1);
            check($sformatf("t2_memreq_msg_%0d", i), memreq_msg, exp_g ? r1 : r0);
            check($sformatf("t2_req0_rdy_%0d", i), req0_rdy, !exp_g);
            check($sformatf("t2_req1_rdy_%0d", i), req1_rdy, exp_g);
         end
         if (i >= 1) begin
            exp_h = ((i - 1) % 2 == 1);
            check($sformatf("t2_resp0_val_%0d", i), resp0_val, !exp_h);
            check($sformatf("t2_resp1_val_%0d", i), resp1_val, exp_h);
            check($sformatf("t2_memresp_rdy_%0d", i), memresp_rdy, 1);
         end
      end
      @(negedge clk);
      idle_inputs();
      #1;
      check("t2_drained", dut.count, 0);

      // ---------------- FIFO full blocks the third request ----------------
      @(negedge clk);
      req0_val = 1'b1; req0_msg = mk_req(3'd0, 8'h41, 32'h4000, 128'h0);
      #1;
      check("t3_first_acc", memreq_val, 1);
      @(negedge clk);
      req0_val = 1'b0;
      req1_val = 1'b1; req1_msg = mk_req(3'd0, 8'h42, 32'h5000, 128'h0);
      #1;
      check("t3_second_acc", req1_rdy, 1);
      @(negedge clk);
      req1_val = 1'b0;
      rc = mk_req(3'd0, 8'h43, 32'h6000, 128'h0);
      req0_val = 1'b1; req0_msg = rc;
      #1;
      check("t3_full_memreq_val", memreq_val, 0);
      check("t3_full_req0_rdy",   req0_rdy,   0);
      @(negedge clk); #1;
      check("t3_full_memreq_val2", memreq_val, 0);
      @(negedge clk);
      memresp_val = 1'b1; memresp_msg = mk_resp(3'd0, 8'h41, 128'h0);
      #1;
      check("t3_deq_memresp_rdy", memresp_rdy, 1);
      check("t3_deq_resp0_val",   resp0_val,   1);
      check("t3_deq_req0_rdy",    req0_rdy,    0);
      check("t3_deq_memreq_val",  memreq_val,  0);
      @(negedge clk);
      memresp_val = 1'b0;
      #1;
      check("t3_third_rdy", req0_rdy,   1);
      check("t3_third_val", memreq_val, 1);
      check("t3_third_msg", memreq_msg, rc);

      // ---------------- port-1 head held while resp1_rdy = 0 ----------------
      @(negedge clk);
      req0_val = 1'b0;
      memresp_val = 1'b1; memresp_msg = mk_resp(3'd0, 8'h42, 128'h0);
      resp1_rdy = 1'b0; resp0_rdy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("t4_hold_memresp_rdy_%0d", k), memresp_rdy, 0);
         check($sformatf("t4_hold_resp1_val_%0d", k),   resp1_val,   1);
         check($sformatf("t4_hold_resp0_val_%0d", k),   resp0_val,   0);
         @(negedge clk);
      end
      resp1_rdy = 1'b1;
      #1;
      check("t4_release_memresp_rdy", memresp_rdy, 1);
      check("t4_release_resp1_val",   resp1_val,   1);
      @(negedge clk);
      memresp_val = 1'b0;
      req1_val = 1'b1; req1_msg = mk_req(3'd0, 8'h44, 32'h7000, 128'h0);
      #1;
      check("t4_refill_req1_rdy", req1_rdy, 1);

      // ---------------- reset with two outstanding ----------------
      @(negedge clk);
      req1_val = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      memresp_val = 1'b1; memresp_msg = mk_resp(3'd0, 8'h99, 128'h0);
      resp0_rdy = 1'b1; resp1_rdy = 1'b1;
      req0_val = 1'b1; req1_val = 1'b1; memreq_rdy = 1'b1;
      #1;
      check("t5_count",       dut.count,    0);
      check("t5_prio",        dut.prio_reg, 0);
      check("t5_memresp_rdy", memresp_rdy,  0);
      check("t5_resp0_val",   resp0_val,    0);
      check("t5_resp1_val",   resp1_val,    0);
      check("t5_memreq_val",  memreq_val,   1);
      check("t5_req0_rdy",    req0_rdy,     1);
      check("t5_req1_rdy",    req1_rdy,     0);
      @(negedge clk);
      idle_inputs();
      reset = 1'b0;

`ifdef LAB3_MEM_ARB_STATS_EN
      // ---------------- statistics counters ----------------
      #1;
      check("st_rst_g0",    num_grants0, 0);
      check("st_rst_g1",    num_grants1, 0);
      check("st_rst_stall", num_stall,   0);
      for (int n = 0; n < 5; n++) do_txn(1'b0);
      for (int n = 0; n < 3; n++) do_txn(1'b1);
      @(negedge clk);
      memreq_rdy = 1'b0; req0_val = 1'b1;
      repeat (4) @(negedge clk);
      req0_val = 1'b0; memreq_rdy = 1'b1;
      #1;
      check("st_g0",    num_grants0, 5);
      check("st_g1",    num_grants1, 3);
      check("st_stall", num_stall,   4);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
